// File: rtl/hazard_ctrl.sv
// Decode-stage sequencing: load-use, flag and branch-register stalls, taken flush, HLT drain.
// Optional HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] id_srcA,
    input  logic [3:0] id_srcB,
    input  logic       id_useA,
    input  logic       id_useB,
    input  logic       id_branch,
    input  logic       id_branch_reg,
    input  logic       id_taken,
    input  logic       id_halt,
    input  logic       ex_regWrite,
    input  logic       ex_memRead,
    input  logic       ex_setsFlags,
    input  logic [3:0] ex_dst,
    input  logic       mem_regWrite,
    input  logic       mem_memRead,
    input  logic [3:0] mem_dst,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       draining,
    output logic       halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0] perf_stall,
    output logic [15:0] perf_flush
`endif
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t     state, stateNext;
    logic [2:0] cnt, cntNext;
    logic       luHit, flHit, brsHit, stall;
    logic       stallRun, flushRun;

    assign luHit = ex_memRead & ex_regWrite & (ex_dst != 4'd0) &
                   ((id_useA & (id_srcA == ex_dst)) |
                    (id_useB & (id_srcB == ex_dst)));

    assign flHit = id_branch & ex_setsFlags;

    // ALU results already in MEM are forwarded, only a load there stalls
    assign brsHit = id_branch_reg & (id_srcB != 4'd0) &
                    ((ex_regWrite & (ex_dst == id_srcB)) |
                     (mem_regWrite & mem_memRead & (mem_dst == id_srcB)));

    assign stall = luHit | flHit | brsHit;

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        draining    = 1'b0;
        halted      = 1'b0;
        stallRun    = 1'b0;
        flushRun    = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            stateNext   = RUN;
            cntNext     = 3'd0;
        end else begin
            unique case (state)
                RUN: begin
                    if (stall) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        stallRun    = 1'b1;
                    end else if (id_branch & id_taken) begin
                        ifid_flush = 1'b1;
                        flushRun   = 1'b1;
                    end else if (id_halt) begin
                        pc_write   = 1'b0;
                        ifid_flush = 1'b1;
                        stateNext  = DRAIN;
                        cntNext    = DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    draining    = 1'b1;
                    if (cnt == 3'd0) stateNext = HALTED;
                    else cntNext = cnt - 3'd1;
                end
                HALTED: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    halted      = 1'b1;
                end
                default: stateNext = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall <= 16'd0;
            perf_flush <= 16'd0;
        end else begin
            if (stallRun && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
            if (flushRun && perf_flush != 16'hFFFF)
                perf_flush <= perf_flush + 16'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the decode stage of the 16-bit five-stage CPU. It watches the instruction in IF/ID and the instructions in ID/EX and EX/MEM, and drives the PC and pipeline-register write enables and the flush and bubble controls. It handles three cases:
- load-use stalls;
- flag and branch-register hazards for branches resolved in decode;
- taken-branch flushes and the HLT drain sequence.

It is the only block allowed to freeze or flush the front end.

## Interface
Parameters:
- DRAIN_CYCLES, 3: cycles spent in DRAIN after HLT leaves ID (covers EX, MEM and WB); legal range 1–7.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- id_srcA, id_srcB  in  4 each  source register numbers of the IF/ID instruction
- id_useA, id_useB  in  1 each  instruction actually reads srcA/srcB
- id_branch  in  1  conditional branch in ID (B or BR)
- id_branch_reg  in  1  branch target comes from a register (BR)
- id_taken  in  1  branch unit reports taken
- id_halt  in  1  HLT opcode in ID
- ex_regWrite, ex_memRead, ex_setsFlags  in  1 each  control bits of the ID/EX instruction
- ex_dst  in  4  destination register of the ID/EX instruction
- mem_regWrite, mem_memRead  in  1 each  control bits of the EX/MEM instruction
- mem_dst  in  4  destination register of the EX/MEM instruction
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads zeroed control bits
- draining  out  1  FSM is in DRAIN
- halted  out  1  FSM is in HALTED

## Operation
- Register number 0 never causes a hazard.
- Load-use stall (LU): ex_memRead & ex_regWrite & ex_dst≠0 & ((id_useA & id_srcA==ex_dst) | (id_useB & id_srcB==ex_dst)).
- Flag stall (FL): id_branch & ex_setsFlags. Flags are written at the end of EX.
- Branch-register stall (BRS): id_branch_reg & id_srcB≠0, and the register is still being produced. That is the case when either holds:
  - ex_regWrite & ex_dst==id_srcB;
  - mem_regWrite & mem_memRead & mem_dst==id_srcB.
  ALU results in MEM are forwarded into ID and do not stall.
- stall = LU | FL | BRS.
- Output priority: stall > taken flush > halt.

FSM states:
- RUN, with combinational outputs:
  - stall: pc_write=0, ifid_write=0, idex_bubble=1.
  - Otherwise, if id_branch & id_taken: pc_write=1, ifid_write=1, ifid_flush=1.
  - Otherwise, if id_halt: pc_write=0, ifid_flush=1, and the next state is DRAIN with the counter loaded to DRAIN_CYCLES−1. The HLT itself passes to ID/EX.
  - Otherwise all enables are 1 and flush/bubble are 0.
  - id_taken and id_halt are ignored while stall=1; they are re-evaluated on the next cycle.
- DRAIN:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, draining=1.
  - The counter decrements each cycle. At 0 the next state is HALTED.
  - All hazard inputs are ignored.
- HALTED:
  - Same enables as DRAIN, with halted=1 and draining=0.
  - This state is terminal; only reset leaves it.
- Drain counter width is 3 bits.

Reset:
- While rst_n=0 at a clock edge, the state becomes RUN and the counter is cleared to 0.
- During a cycle in which rst_n is low, outputs are forced regardless of state or inputs: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, draining=0, halted=0.
- Reset asserted mid-DRAIN aborts the drain with no residual state.

## Timing
- All hazard and flush outputs are combinational from the current inputs and state. There is zero-cycle latency from a hazard to its control.
- LU holds for exactly 1 cycle: the load moves to MEM, where its data is forwarded to EX.
- FL holds for 1 cycle.
- BRS holds for 1 cycle when the producer is an ALU op in EX, and 2 cycles when it is a load in EX.
- A taken branch costs exactly 1 bubble (the flushed fetch).
- HLT in ID at cycle N:
  - DRAIN covers cycles N+1 … N+DRAIN_CYCLES.
  - halted first reads 1 in cycle N+DRAIN_CYCLES+1.
- A flag or register hazard on a taken branch delays the flush until the cycle the stall clears. The flush is never issued in the same cycle as a stall.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds output perf_stall (16 bits): counts RUN cycles with stall=1.
  - Adds output perf_flush (16 bits): counts taken flushes.
  - Both counters saturate at 0xFFFF, clear on reset, and freeze in DRAIN and HALTED.
- HAZARD_PERF_EN undefined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
- LW R3 in EX (ex_memRead=1, ex_regWrite=1, ex_dst=3) with ID reading srcA=3, useA=1 → pc_write=0, ifid_write=0, idex_bubble=1 for one cycle. The same case with ex_dst=0 → no stall.
- ADD R5 in EX and BR R5 in ID, then the load case (LW R5 in EX) → 1-cycle stall for the ADD and 2-cycle stall for the load. ADD R5 in MEM → no stall.
- ex_setsFlags=1 and a B with id_taken=1 in ID → cycle 1: bubble and no flush. Cycle 2, with ex_setsFlags=0: ifid_flush=1 and pc_write=1.
- id_halt=1 in RUN with DRAIN_CYCLES=3 → draining=1 for exactly 3 cycles, then halted=1. Toggling hazard inputs during DRAIN has no effect. rst_n=0 for one cycle returns to RUN with all outputs at their reset values.
- HLT in ID while LU is active → no transition that cycle; DRAIN starts on the cycle after the stall clears.
- With HAZARD_PERF_EN: 5 stall cycles and 2 taken branches → perf_stall=5 and perf_flush=2. Preload near 0xFFFF and continue stalling → perf_stall stays at 0xFFFF.
